// File: rtl/gpio_irq_ctrl_if.sv
// gpio_irq_ctrl_if: simple synchronous peripheral bus for the GPIO interrupt controller.
//   sel   - access strobe, one cycle per access
//   we    - write enable, qualified by sel
//   addr  - register index
//   wdata - write data
//   rdata - read data, registered by the slave, valid the cycle after a read
interface gpio_irq_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         sel;
    logic         we;
    logic [2:0]   addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: latches selected per-pin edges into pending flags, masks them and
// raises a single level interrupt; configured through a small register file.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active-high
//   lvl   - synchronised pin levels from the filter stages
//   rise  - one-cycle rising-edge pulses from the filter stages
//   fall  - one-cycle falling-edge pulses from the filter stages
//   bus   - peripheral bus (sel/we/addr/wdata in, registered rdata out)
//   irq   - interrupt request, level, registered
//
// Register map: 0 LEVEL (RO), 1 RISE_EN, 2 FALL_EN, 3 PENDING (W1C), 4 MASK,
// 5 STATUS = PENDING & MASK (RO), 6/7 read zero.
//
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN. When defined, each pin gets its own
// stability counter; edges are derived internally from the debounced level and the
// external rise/fall ports are ignored. LEVEL then reports the debounced level.
module gpio_irq_ctrl #(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       lvl,
    input  logic [N-1:0]       rise,
    input  logic [N-1:0]       fall,
    gpio_irq_ctrl_if.slave     bus,
    output logic               irq
);
    localparam logic [2:0] A_LEVEL   = 3'd0;
    localparam logic [2:0] A_RISE_EN = 3'd1;
    localparam logic [2:0] A_FALL_EN = 3'd2;
    localparam logic [2:0] A_PENDING = 3'd3;
    localparam logic [2:0] A_MASK    = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;

    // Elaboration-time parameter sanity checks
    if (N < 1 || N > 32) begin : g_bad_n
        $error("gpio_irq_ctrl: N must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("gpio_irq_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] pending;
    logic [N-1:0] mask;

    logic [N-1:0] lvl_eff_c;
    logic [N-1:0] rise_eff_c;
    logic [N-1:0] fall_eff_c;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N-1:0]  stable;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  db_rise;
    logic [N-1:0]  db_fall;

    // External edge pulses are superseded by the debouncer
    logic unused_ext_edges;
    assign unused_ext_edges = ^{rise, fall};

    // Per-pin debouncer: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive differing cycles; the accept cycle emits a one-cycle edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable  <= '0;
            db_rise <= '0;
            db_fall <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                db_rise[i] <= 1'b0;
                db_fall[i] <= 1'b0;
                if (lvl[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i]  <= lvl[i];
                    cnt[i]     <= '0;
                    db_rise[i] <= lvl[i];
                    db_fall[i] <= ~lvl[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign lvl_eff_c  = stable;
    assign rise_eff_c = db_rise;
    assign fall_eff_c = db_fall;
`else
    assign lvl_eff_c  = lvl;
    assign rise_eff_c = rise;
    assign fall_eff_c = fall;
`endif

    logic         wr_c;
    logic         rd_c;
    logic [N-1:0] set_c;
    logic [N-1:0] clr_c;
    logic [N-1:0] rd_mux_c;

    assign wr_c  = bus.sel &  bus.we;
    assign rd_c  = bus.sel & ~bus.we;
    assign set_c = (rise_eff_c & rise_en) | (fall_eff_c & fall_en);
    assign clr_c = (wr_c && bus.addr == A_PENDING) ? bus.wdata : '0;

    // Read mux operates on pre-update state so a same-cycle set is not visible
    always_comb begin
        rd_mux_c = '0;
        case (bus.addr)
            A_LEVEL:   rd_mux_c = lvl_eff_c;
            A_RISE_EN: rd_mux_c = rise_en;
            A_FALL_EN: rd_mux_c = fall_en;
            A_PENDING: rd_mux_c = pending;
            A_MASK:    rd_mux_c = mask;
            A_STATUS:  rd_mux_c = pending & mask;
            default:   rd_mux_c = '0;
        endcase
    end

    // Configuration, pending latch (set beats clear), interrupt and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_en   <= '0;
            fall_en   <= '0;
            pending   <= '0;
            mask      <= '0;
            irq       <= 1'b0;
            bus.rdata <= '0;
        end else begin
            if (wr_c) begin
                case (bus.addr)
                    A_RISE_EN: rise_en <= bus.wdata;
                    A_FALL_EN: fall_en <= bus.wdata;
                    A_MASK:    mask    <= bus.wdata;
                    default:   ;
                endcase
            end
            pending <= (pending & ~clr_c) | set_c;
            irq     <= |(pending & mask);
            if (rd_c) begin
                bus.rdata <= rd_mux_c;
            end
        end
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed scenarios plus randomized traffic checked against a
// register-level behavioural model of the interrupt controller.
module tb_gpio_irq_ctrl;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         irq;

    gpio_irq_ctrl_if #(.N(N)) bus ();

    gpio_irq_ctrl #(.N(N), .DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall),
        .bus  (bus),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit use_model = 1'b1;

    // Behavioural model state: one value per architectural register
    logic [N-1:0] m_ren, m_fen, m_pend, m_mask, m_rdata;
    logic         m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_reg(input logic [2:0] a, input logic [N-1:0] l);
        case (a)
            3'd0:    return l;
            3'd1:    return m_ren;
            3'd2:    return m_fen;
            3'd3:    return m_pend;
            3'd4:    return m_mask;
            3'd5:    return m_pend & m_mask;
            default: return '0;
        endcase
    endfunction

    // Advance the model by one clock using the values sampled at that edge
    task automatic m_step(input bit r, input bit s, input bit w, input logic [2:0] a,
                          input logic [N-1:0] wd, input logic [N-1:0] ri, input logic [N-1:0] fa);
        logic [N-1:0] nxt;
        logic         any;
        if (r) begin
            m_ren = '0; m_fen = '0; m_pend = '0; m_mask = '0; m_rdata = '0; m_irq = 1'b0;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_mask[i]) any = 1'b1;
        end
        if (s && !w) m_rdata = m_reg(a, lvl);
        for (int i = 0; i < N; i++) begin
            bit keep, clr, st;
            clr  = s && w && (a == 3'd3) && wd[i];
            st   = (ri[i] && m_ren[i]) || (fa[i] && m_fen[i]);
            keep = m_pend[i] && !clr;
            nxt[i] = keep || st;
        end
        m_pend = nxt;
        if (s && w && a == 3'd1) m_ren  = wd;
        if (s && w && a == 3'd2) m_fen  = wd;
        if (s && w && a == 3'd4) m_mask = wd;
        m_irq = any;
    endtask

    task automatic tick(input bit r, input bit s, input bit w, input logic [2:0] a,
                        input logic [N-1:0] wd, input logic [N-1:0] ri, input logic [N-1:0] fa);
        rst = r; bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = wd; rise = ri; fall = fa;
        @(posedge clk);
        if (use_model) m_step(r, s, w, a, wd, ri, fa);
        #1;
        rst = 1'b0; bus.sel = 1'b0; bus.we = 1'b0; rise = '0; fall = '0;
        if (use_model) begin
            check("rdata", 32'(bus.rdata), 32'(m_rdata));
            check("irq", 32'(irq), 32'(m_irq));
        end
    endtask

    task automatic idle();                                   tick(0, 0, 0, 3'd0, '0, '0, '0); endtask
    task automatic wr(input logic [2:0] a, input logic [N-1:0] d); tick(0, 1, 1, a, d, '0, '0); endtask
    task automatic rd(input logic [2:0] a);                  tick(0, 1, 0, a, '0, '0, '0); endtask

    initial begin
        rst = 1'b1; lvl = '0; rise = '0; fall = '0;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        tick(1, 0, 0, 3'd0, '0, '0, '0);
        tick(1, 0, 0, 3'd0, '0, '0, '0);

        // Reset state: every address reads zero, no interrupt
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("reset_read", 32'(bus.rdata), 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
        use_model = 1'b0;
        wr(3'd1, 8'h01);
        lvl = 8'h01; idle(); idle(); idle();
        lvl = 8'h00; idle(); idle(); idle();
        rd(3'd3);
        check("db_short_glitch", 32'(bus.rdata), 32'd0);
        lvl = 8'h01; idle(); idle(); idle(); idle(); idle(); idle();
        rd(3'd3);
        check("db_pending", 32'(bus.rdata), 32'h01);
        rd(3'd0);
        check("db_level", 32'(bus.rdata), 32'h01);
`else
        // Rising edge on pin 0: pending at T+1, irq at T+2, cleared by W1C
        wr(3'd1, 8'h01);
        wr(3'd4, 8'h01);
        tick(0, 0, 0, 3'd0, '0, 8'h01, '0);
        check("rise0_irq_t1", 32'(irq), 32'd0);
        idle();
        check("rise0_irq_t2", 32'(irq), 32'd1);
        rd(3'd3);
        check("rise0_pending", 32'(bus.rdata), 32'h01);
        wr(3'd3, 8'h01);
        check("w1c_irq_t1", 32'(irq), 32'd1);
        idle();
        check("w1c_irq_t2", 32'(irq), 32'd0);

        // Masked fall on pin 7 latches but does not interrupt until unmasked
        wr(3'd2, 8'h80);
        wr(3'd4, 8'h00);
        tick(0, 0, 0, 3'd0, '0, '0, 8'h80);
        rd(3'd3);
        check("fall7_pending", 32'(bus.rdata), 32'h80);
        rd(3'd5);
        check("fall7_status", 32'(bus.rdata), 32'h00);
        check("fall7_irq_masked", 32'(irq), 32'd0);
        wr(3'd4, 8'h80);
        check("unmask_irq_t1", 32'(irq), 32'd0);
        idle();
        check("unmask_irq_t2", 32'(irq), 32'd1);

        // Same-cycle set and clear: set wins
        wr(3'd3, 8'hFF);
        wr(3'd1, 8'h04);
        tick(0, 0, 0, 3'd0, '0, 8'h04, '0);
        tick(0, 1, 1, 3'd3, 8'h04, 8'h04, '0);
        rd(3'd3);
        check("set_beats_clr", 32'(bus.rdata), 32'h04);

        // Disabled edges are dropped, not deferred
        wr(3'd3, 8'hFF);
        wr(3'd1, 8'h00);
        tick(0, 0, 0, 3'd0, '0, 8'h08, '0);
        wr(3'd1, 8'h08);
        rd(3'd3);
        check("no_retro_set", 32'(bus.rdata), 32'h00);
        tick(0, 0, 0, 3'd0, '0, 8'h08, '0);
        rd(3'd3);
        check("late_rise3", 32'(bus.rdata), 32'h08);

        // Reset while interrupting
        wr(3'd4, 8'hFF);
        idle();
        check("pre_rst_irq", 32'(irq), 32'd1);
        tick(1, 0, 0, 3'd0, '0, '0, '0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int a = 1; a < 6; a++) begin
            rd(3'(a));
            check("rst_regs", 32'(bus.rdata), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit r, s, w;
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 2) == 0);
            w   = $urandom_range(0, 1) == 1;
            lvl = N'($urandom);
            tick(r, s, w, 3'($urandom), N'($urandom),
                 N'($urandom & $urandom), N'($urandom & $urandom));
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Consumes the synchronised level and the single-cycle rise/fall pulses from a bank of per-pin input filter stages.
- Latches selected edges into per-pin pending flags, masks them and raises one level interrupt to the hs32 core.
- Exposes a small register file on a simple synchronous peripheral bus for configuration, status and write-1-to-clear.

Parameters:
- N, 8, number of GPIO input pins (1..32)
- DEBOUNCE_CYCLES, 16, stable cycles required before a level change is accepted (used only with GPIO_IRQ_DEBOUNCE_EN; >=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lvl  in  N  synchronised pin levels from filter stages
- rise  in  N  one-cycle rising-edge pulses from filter stages
- fall  in  N  one-cycle falling-edge pulses from filter stages
- sel  in  1  bus access strobe, one cycle per access
- we  in  1  write enable, qualified by sel
- addr  in  3  register index
- wdata  in  N  write data
- rdata  out  N  read data, registered
- irq  out  1  interrupt request, level, registered

Behaviour:
- Interface fixed: one clock, clk; rst is synchronous and active-high.
- Reset: RISE_EN, FALL_EN, PENDING, MASK = 0; rdata = 0; irq = 0.
- Register map (addr):
  - 0 LEVEL: RO, current lvl.
  - 1 RISE_EN: RW.
  - 2 FALL_EN: RW.
  - 3 PENDING: read; write-1-to-clear.
  - 4 MASK: RW, 1 = pin may interrupt.
  - 5 STATUS: RO, PENDING & MASK.
  - 6, 7: read 0; writes ignored.
- Writes to RO registers are ignored.
- Set rule: set[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Pending update per bit, every cycle: PENDING <= (PENDING & ~clr) | set.
  - clr = wdata on a PENDING write (sel & we & addr==3), else 0.
  - Set wins over a same-cycle clear of the same bit.
- Edge latency:
  - pulse at cycle T -> PENDING bit visible at T+1.
  - irq <= |(PENDING & MASK), so irq rises at T+2.
- Enable gating:
  - Edges arriving while the enable bit is 0 are discarded, not deferred.
  - Enabling a bit does not retroactively set PENDING.
- MASK affects only irq and STATUS. Masked pins still latch PENDING.
- irq deasserts one cycle after the last unmasked pending bit is cleared or masked.
- Reads: sel & ~we at T -> rdata valid at T+1 and held until the next read.
  - Reads have no side effects.
  - A read in the same cycle as a set returns the pre-set value.
- Register write takes effect at T+1.
  - Writing RISE_EN/FALL_EN in cycle T gates set from cycle T+1; the pulse in cycle T uses the old enable.
- Simultaneous rise and fall on one pin (not produced upstream) is tolerated: set per rule.
- Reset mid-operation clears all state, including pending bits and an asserted irq, in the next cycle.

Optional Feature:
- Macro: GPIO_IRQ_DEBOUNCE_EN.
- Defined:
  - Per-pin stable register (reset 0) and counter (width clog2(DEBOUNCE_CYCLES+1), reset 0).
  - While lvl[i] != stable[i], the counter increments each cycle.
  - When lvl[i] == stable[i], the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 and lvl still differs: stable[i] toggles, the counter clears, and an internal one-cycle rise or fall pulse is generated from the new stable value.
  - External rise/fall ports are ignored.
  - LEVEL reads stable.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Undefined: rise/fall ports drive edge detection directly; LEVEL reads lvl; no counters are synthesised.

Test Plan:
- Reset, then read all 8 addresses -> rdata 0 for each; irq 0.
- Set RISE_EN=0x01, MASK=0x01; pulse rise[0] at T -> PENDING=0x01 at T+1, irq=1 at T+2. Write PENDING=0x01 -> irq=0 two cycles later.
- Set FALL_EN=0x80, MASK=0; pulse fall[7] -> PENDING=0x80, STATUS=0, irq stays 0. Then write MASK=0x80 -> irq=1 two cycles after the write.
- PENDING=0x04; in one cycle, write PENDING=0x04 while rise[2] pulses with RISE_EN[2]=1 -> PENDING remains 0x04.
- Pulse rise[3] with RISE_EN=0, then set RISE_EN=0x08 -> PENDING stays 0; a later rise[3] sets 0x08. Assert rst while irq=1 -> irq=0, all registers 0.
- With GPIO_IRQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, FALL_EN=0, RISE_EN=0x01:
  - lvl[0] high for 3 cycles -> no PENDING.
  - lvl[0] high for 4 cycles -> PENDING=0x01 and LEVEL bit0=1.
